// File: rtl/perm_out_buffer.sv
// perm_out_buffer: collects permuted words from the permutation controller
// into a register array, then streams them out in capture order over a
// valid/ready handshake once the controller reports ready. Re-armed by start.
module perm_out_buffer #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 25,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              write_output,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  word_count
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DRAIN   = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic              overflow_q;
    logic              out_valid_q;
    logic              done_q;
    logic [WORD_W-1:0] mem_q [DEPTH];

    logic full;
    logic wr_en;
    logic drop;
    logic last_rd;

    // Decode capture/drop decisions and the count as it will be after this edge.
    always_comb begin
        full         = (word_count_q == DEPTH_C);
        wr_en        = !start && (state_q == S_COLLECT) && write_output && !full;
        drop         = !start && write_output && ((state_q != S_COLLECT) || full);
        wr_ptr_d     = wr_en ? (wr_ptr_q + ONE_C) : wr_ptr_q;
        word_count_d = wr_en ? (word_count_q + ONE_C) : word_count_q;
        last_rd      = (rd_ptr_q == (word_count_q - ONE_C));
    end

    // Control FSM: pointers, sticky overflow and registered valid/done flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_COLLECT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else if (start) begin
            state_q      <= S_COLLECT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                S_COLLECT: begin
                    wr_ptr_q     <= wr_ptr_d;
                    word_count_q <= word_count_d;
                    if (ready) begin
                        rd_ptr_q <= '0;
                        if (word_count_d != '0) begin
                            state_q     <= S_DRAIN;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (last_rd) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + ONE_C;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_COLLECT;
                    out_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    // Word storage: data only, no reset needed since contents are gated by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign out_data   = out_valid_q ? mem_q[rd_ptr_q] : '0;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: doc/perm_out_buffer.md
Name: perm_out_buffer

Overview:
- Downstream stage of the permutation controller.
- Captures each permuted word on the controller's `write_output` strobe into an internal register-array buffer.
- When the controller raises `ready`, drains the buffered words in capture order over a valid/ready stream to the consumer, then flags completion.
- Re-armed by `start`, the same start pulse that launches the permutation controller.

Parameters:
- WORD_W, 64, width of one permuted word
- DEPTH, 25, number of buffer entries (words per permutation)
- CNT_W, 5, pointer/count width; must satisfy 2^CNT_W >= DEPTH

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous active-low reset
- start  input  1  re-arm; same signal that drives the controller start
- write_output  input  1  controller strobe: capture wr_data this cycle
- wr_data  input  WORD_W  permuted word from datapath register
- ready  input  1  controller finished; begin drain
- out_data  output  WORD_W  word presented to consumer
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- done  output  1  all buffered words delivered
- overflow  output  1  sticky: a write was dropped
- word_count  output  CNT_W  number of words currently captured

Behaviour:
- Reset (reset_n=0, async):
  - state=COLLECT, wr_ptr=0, rd_ptr=0, word_count=0.
  - out_valid=0, done=0, overflow=0.
  - out_data=0; buffer contents are don't-care.
- States: COLLECT, DRAIN, DONE.
  - State, pointers and flags are registered.
  - out_valid=(state==DRAIN); done=(state==DONE); out_data=mem[rd_ptr], combinational read.
- COLLECT:
  - write_output=1 with word_count<DEPTH: mem[wr_ptr]<=wr_data, then wr_ptr and word_count increment at the same edge.
  - write_output=1 with word_count==DEPTH: word dropped, overflow<=1, pointers unchanged.
  - ready=1 with word_count after this edge >0: next state is DRAIN.
  - ready=1 with word_count after this edge ==0: next state is DONE.
  - write_output and ready high in the same cycle: the write is captured and is included in the drain.
- DRAIN:
  - A transfer occurs on a cycle with out_valid=1 and out_ready=1; rd_ptr increments on that transfer.
  - Transfer with rd_ptr==word_count-1: next state is DONE, rd_ptr held.
  - out_ready=0: out_data and rd_ptr stable; no word skipped or repeated.
  - write_output=1 in DRAIN: word dropped, overflow<=1.
- DONE:
  - done=1, held until start or reset.
  - write_output=1: word dropped, overflow<=1.
- start=1, any state, synchronous, highest priority:
  - next state is COLLECT; wr_ptr, rd_ptr and word_count go to 0; overflow and done go to 0.
  - A write_output in the same cycle is discarded (controller is in Init then and never writes).
- Latency:
  - First out_valid one cycle after ready is sampled high.
  - One word per cycle when out_ready is held high.
  - done is asserted the cycle after the last transfer.
- No wrap-around: pointers never exceed DEPTH-1 for captured entries; a full buffer refuses writes instead of overwriting.
- reset_n mid-drain aborts immediately: out_valid=0 asynchronously and the buffer is treated as empty.

Test Plan:
- Nominal run:
  - Stimulus: reset, start pulse, 25 write_output strobes with wr_data=i (i=0..24) at 3-cycle spacing, then ready; out_ready held 1.
  - Required: out_data sequence 0..24 on 25 consecutive cycles, out_valid first high 1 cycle after ready, done=1 the cycle after word 24, overflow=0.
- Backpressure:
  - Stimulus: as nominal, with out_ready toggling 1,0,0,1,...
  - Required: each word appears exactly once, out_data stable while out_ready=0, done only after 25 transfers.
- Overflow:
  - Stimulus: 27 writes before ready.
  - Required: word_count=25, overflow=1, drained data = first 25 words.
- Simultaneous events:
  - Stimulus: write_output with wr_data=0xA5 and ready high in the same cycle after 3 prior writes.
  - Required: 4 words drained, the last being 0xA5.
  - Stimulus: ready with 0 words.
  - Required: done next cycle, out_valid never 1.
- Restart and reset:
  - Stimulus: start asserted mid-DRAIN after 10 transfers.
  - Required: next cycle out_valid=0, word_count=0, done=0, overflow cleared; a following 25-word run behaves as nominal.
  - Stimulus: reset_n pulsed low mid-COLLECT, asynchronous to clk.
  - Required: outputs at reset values immediately.
